hero_burst_gather: RTL and testbench

HERO_BURST_GATHER -- requirements
Module: hero_burst_gather

---
 rtl/hero_burst_gather_pkg.sv | 29 ++
 rtl/hero_burst_gather.sv | 115 +++++++++++
 tb/tb_hero_burst_gather.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hero_burst_gather_pkg.sv
// Shared types for the hero write burst gatherer: cycle type encoding, beat and bundle types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hero_burst_gather_pkg;

  // Default beat width and bundle capacity used by the gatherer and its consumers
  localparam int HERO_WIDTH = 32;
  localparam int MAX_BEATS  = 5;

  // Per-cycle qualifier on the hero write stream; value 3 is never legal
  typedef enum logic [1:0] {
    CYCLE_IDLE    = 2'd0,
    CYCLE_VALID   = 2'd1,
    CYCLE_DONE    = 2'd2,
    CYCLE_ILLEGAL = 2'd3
  } CYCLE_TYPE_E;

  // One hero write data beat
  typedef logic [HERO_WIDTH-1:0] hero_write_t;

  // A gathered bundle: MAX_BEATS beats, beat i in element i
  typedef hero_write_t [MAX_BEATS-1:0] hero_bundle_t;

  // True for cycle types that carry a payload beat
  function automatic logic carries_beat(input CYCLE_TYPE_E t);
    return (t == CYCLE_VALID) || (t == CYCLE_DONE);
  endfunction

endpackage

// File: rtl/hero_burst_gather.sv
// Gathers hero write beats into bundles of up to MAX_BEATS, closed by DONE or by a full bundle.
// Latency: out_valid rises the cycle after the closing beat is accepted.
// Backpressure: in_ready is low for the whole HOLD state; bundle held stable until out_ready.
module hero_burst_gather #(
  parameter int HERO_WIDTH = hero_burst_gather_pkg::HERO_WIDTH,
  parameter int MAX_BEATS  = hero_burst_gather_pkg::MAX_BEATS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        in_cycle_type,
  input  logic [HERO_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAX_BEATS*HERO_WIDTH-1:0]   out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]    out_count,
  output logic                              out_last,
  output logic                              err_illegal
);
  import hero_burst_gather_pkg::*;

  localparam int PTR_W = $clog2(MAX_BEATS);
  localparam int CNT_W = $clog2(MAX_BEATS+1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_BEATS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e                                state;
  state_e                                state_nxt;
  logic [MAX_BEATS-1:0][HERO_WIDTH-1:0]  slots;
  logic [PTR_W-1:0]                      wr_ptr;
  CYCLE_TYPE_E                           cycle;
  logic                                  is_done;
  logic                                  beat_acc;
  logic                                  close_bundle;

  assign cycle = CYCLE_TYPE_E'(in_cycle_type);
  assign is_done = (cycle == CYCLE_DONE);

  // Handshake outputs are pure functions of state, so in_ready never sees out_ready.
  // Both are forced low while rst is high, before the state register has been cleared.
  assign in_ready  = (state == COLLECT) && !rst;
  assign out_valid = (state == HOLD) && !rst;

  // Slots are cleared on every bundle release, so unwritten slots already read 0.
  // The reset gate covers the first reset cycle, when the slots still hold old data.
  assign out_data = rst ? '0 : slots;

  assign beat_acc     = in_ready && carries_beat(cycle);
  assign close_bundle = beat_acc && (is_done || (wr_ptr == LAST_SLOT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: close a bundle on DONE or on the beat that fills the last slot; release on out_ready
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (close_bundle) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Slot array, write pointer and bundle descriptor
  always_ff @(posedge clk) begin
    if (rst) begin
      slots     <= '0;
      wr_ptr    <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (state == COLLECT) begin
      if (beat_acc) begin
        slots[wr_ptr] <= in_data;
        wr_ptr        <= wr_ptr + PTR_W'(1);
        if (close_bundle) begin
          out_count <= CNT_W'(wr_ptr) + CNT_W'(1);
          out_last  <= is_done;
        end
      end
    end else if (out_ready) begin
      slots     <= '0;
      wr_ptr    <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end
  end

  // Illegal cycle type flag: a one-cycle pulse, only ever raised from COLLECT
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= (state == COLLECT) && (cycle == CYCLE_ILLEGAL);
    end
  end

endmodule

// File: tb/tb_hero_burst_gather.sv
// Bench for hero_burst_gather: directed beats, expected bundles queued, monitor compares on handshake.
// Latency: checks out_valid one cycle after the closing beat.
// Backpressure: exercises out_ready held low and in_ready gaps.
module tb_hero_burst_gather;
  import hero_burst_gather_pkg::*;

  localparam int W   = 32;
  localparam int N   = 5;
  localparam int CW  = $clog2(N+1);
  localparam int DW  = N*W;

  logic           clk;
  logic           rst;
  logic [1:0]     in_cycle_type;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_count;
  logic           out_last;
  logic           err_illegal;

  typedef struct {
    logic [DW-1:0] data;
    int            count;
    bit            last;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   err_cnt = 0;
  int   low_cnt = 0;

  hero_burst_gather #(.HERO_WIDTH(W), .MAX_BEATS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_cycle_type (in_cycle_type),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_count     (out_count),
    .out_last      (out_last),
    .err_illegal   (err_illegal)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a bounded wait is mis-coded
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack5(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                          input logic [W-1:0] s2, input logic [W-1:0] s3,
                                          input logic [W-1:0] s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic expect_bundle(input logic [DW-1:0] d, input int c, input bit l);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.last  = l;
    sb.push_back(e);
  endtask

  // Monitor: counts err pulses and in_ready-low cycles, compares each delivered bundle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && err_illegal) err_cnt++;
      if (!rst && !in_ready) low_cnt++;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bundle: got bundle count %0d, expected no bundle", out_count);
        end else begin
          e = sb.pop_front();
          check_v("bundle_data", out_data, e.data);
          check_i("bundle_count", 32'(out_count), 32'(e.count));
          check_i("bundle_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // Present a beat and hold it until accepted (bounded), then return to IDLE
  task automatic send(input logic [1:0] t, input logic [W-1:0] d);
    int waited;
    waited = 0;
    in_cycle_type = t;
    in_data       = d;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_cycle_type = 2'd0;
  endtask

  // Drive one cycle of a non-beat cycle type
  task automatic drive(input logic [1:0] t, input logic [W-1:0] d);
    in_cycle_type = t;
    in_data       = d;
    @(posedge clk);
    #1;
    in_cycle_type = 2'd0;
  endtask

  // Wait (bounded) until the block is collecting again
  task automatic wait_collect();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL collect_timeout: in_ready got 0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios
  initial begin : stim
    int err0;
    rst           = 1'b1;
    out_ready     = 1'b1;
    in_cycle_type = 2'd0;
    in_data       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_i("rst_in_ready", 32'(in_ready), 0);
    check_i("rst_out_valid", 32'(out_valid), 0);
    check_v("rst_out_data", out_data, '0);
    check_i("rst_out_count", 32'(out_count), 0);
    check_i("rst_out_last", 32'(out_last), 0);
    check_i("rst_err_illegal", 32'(err_illegal), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_i("in_ready_after_rst", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Three-beat burst closed by DONE
    expect_bundle(pack5(32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'h0, 32'h0), 3, 1'b1);
    send(2'd1, 32'hA1A1_0001);
    send(2'd1, 32'hA2A2_0002);
    send(2'd2, 32'hA3A3_0003);
    @(negedge clk);
    check_i("s1_out_valid_latency", 32'(out_valid), 1);
    check_i("s1_in_ready_in_hold", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    wait_collect();

    // Seven VALID then DONE: splits into a full bundle and a 3-beat tail
    expect_bundle(pack5(32'h101, 32'h102, 32'h103, 32'h104, 32'h105), 5, 1'b0);
    expect_bundle(pack5(32'h106, 32'h107, 32'h108, 32'h0, 32'h0), 3, 1'b1);
    low_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      send(2'd1, W'(32'h100 + i));
    end
    send(2'd2, 32'h108);
    check_i("s2_in_ready_low_cycles", 32'(low_cnt), 1);
    wait_collect();

    // Lone DONE
    expect_bundle(pack5(32'h0000_DEAD, 32'h0, 32'h0, 32'h0, 32'h0), 1, 1'b1);
    send(2'd2, 32'h0000_DEAD);
    wait_collect();

    // Bundle held under backpressure while VALID and illegal types are driven
    out_ready = 1'b0;
    expect_bundle(pack5(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'h0), 4, 1'b1);
    send(2'd1, 32'hB1);
    send(2'd1, 32'hB2);
    send(2'd1, 32'hB3);
    send(2'd2, 32'hB4);
    err0 = err_cnt;
    in_cycle_type = 2'd1;
    in_data       = 32'h0000_0BAD;
    for (int c = 0; c < 12; c++) begin
      if (c >= 10) in_cycle_type = 2'd3;
      @(negedge clk);
      check_i("s4_hold_out_valid", 32'(out_valid), 1);
      check_i("s4_hold_in_ready", 32'(in_ready), 0);
      check_v("s4_hold_out_data", out_data, pack5(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'h0));
      check_i("s4_hold_out_count", 32'(out_count), 4);
      check_i("s4_hold_out_last", 32'(out_last), 1);
      @(posedge clk);
      #1;
    end
    in_cycle_type = 2'd0;
    @(negedge clk);
    check_i("s4_no_err_in_hold", 32'(err_cnt - err0), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_collect();

    // IDLE / illegal / IDLE interleaved mid-burst
    err0 = err_cnt;
    expect_bundle(pack5(32'hC1, 32'hC2, 32'hC3, 32'h0, 32'h0), 3, 1'b1);
    send(2'd1, 32'hC1);
    drive(2'd0, 32'h1111_1111);
    drive(2'd3, 32'hFFFF_FFFF);
    drive(2'd0, 32'h2222_2222);
    send(2'd1, 32'hC2);
    send(2'd2, 32'hC3);
    wait_collect();
    check_i("s5_err_pulses", 32'(err_cnt - err0), 1);

    // Reset mid-burst discards the partial bundle
    send(2'd1, 32'hD1);
    send(2'd1, 32'hD2);
    rst = 1'b1;
    @(negedge clk);
    check_i("s6_rst_in_ready", 32'(in_ready), 0);
    check_i("s6_rst_out_valid", 32'(out_valid), 0);
    check_v("s6_rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_bundle(pack5(32'h1, 32'h0, 32'h0, 32'h0, 32'h0), 1, 1'b1);
    send(2'd2, 32'h1);
    wait_collect();

    // Reset during HOLD discards the held bundle
    out_ready = 1'b0;
    send(2'd2, 32'hE1);
    @(negedge clk);
    check_i("s7_held_before_rst", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_i("s7_hold_discarded", 32'(out_valid), 0);
    check_i("s7_count_cleared", 32'(out_count), 0);
    @(posedge clk);
    #1;
    expect_bundle(pack5(32'h2, 32'h0, 32'h0, 32'h0, 32'h0), 1, 1'b1);
    send(2'd2, 32'h2);
    wait_collect();

    // Every queued bundle must have been delivered
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(posedge clk);
    end
    check_i("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
